switch_move_scheduler: RTL

//  Turns the 4 debounced switch levels into a queue of discrete move commands for the game logic.
//  - Detects presses and generates auto-repeat while a switch is held.
//  - Shares one command FIFO between the 4 switches through a round-robin arbiter.
//  - Sits between the shared debouncer outputs and the frog movement/state logic.

---
 rtl/switch_move_scheduler_pkg.sv | 15 +
 rtl/switch_move_scheduler_fifo.sv | 59 +++++
 rtl/switch_move_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/switch_move_scheduler_pkg.sv
// rtl/switch_move_scheduler_pkg.sv - shared direction codes and per-switch FSM states
package switch_move_scheduler_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } sw_state_e;

endpackage

// File: rtl/switch_move_scheduler_fifo.sv
// rtl/switch_move_scheduler_fifo.sv - move_fifo: small synchronous FIFO with flush
module move_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop on an empty FIFO is ignored; a push into a full FIFO needs a same-cycle pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/switch_move_scheduler.sv
// rtl/switch_move_scheduler.sv - press/auto-repeat detection, round-robin arbitration into a move FIFO
module switch_move_scheduler
  import switch_move_scheduler_pkg::*;
#(
  parameter int c_REPEAT_DELAY = 12500000,
  parameter int c_REPEAT_RATE  = 3750000,
  parameter int c_FIFO_DEPTH   = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic                          i_Enable,
  input  logic [3:0]                    i_Switches,
  output logic                          o_Move_Valid,
  output logic [1:0]                    o_Move_Dir,
  input  logic                          i_Move_Ready,
  output logic [$clog2(c_FIFO_DEPTH):0] o_Fifo_Count,
  output logic                          o_Drop
);

  localparam int CNT_MAX = (c_REPEAT_DELAY > c_REPEAT_RATE) ? c_REPEAT_DELAY : c_REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic [3:0] prev_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] evt;
  logic [3:0] grant;
  logic [1:0] rr_q, rr_d;
  logic [1:0] grant_idx;
  logic       drop_q, drop_d;
  logic       fifo_full, fifo_empty, fifo_pop;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_sw
      sw_state_e        state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             evt_g;

      assign evt[g] = evt_g;

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Release (or disable) always returns to IDLE and suppresses any same-cycle event.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_g   = 1'b0;
        if (!i_Enable || !i_Switches[g]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (!prev_q[g]) begin
                evt_g   = 1'b1;
                state_d = ST_DELAY;
                cnt_d   = '0;
              end
            end
            ST_DELAY: begin
              if (cnt_q == CNT_W'(c_REPEAT_DELAY - 1)) begin
                evt_g   = 1'b1;
                state_d = ST_REPEAT;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            ST_REPEAT: begin
              if (cnt_q == CNT_W'(c_REPEAT_RATE - 1)) begin
                evt_g = 1'b1;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            default: begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign fifo_pop = o_Move_Valid & i_Move_Ready;

  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant     = '0;
    grant_idx = rr_q;
    rr_d      = rr_q;
    idx       = '0;
    found     = 1'b0;
    if (i_Enable && (!fifo_full || fifo_pop)) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_q + 2'(k);
        if (!found && pend_q[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          rr_d       = idx + 2'd1;
          found      = 1'b1;
        end
      end
    end
  end

  // An event lands on a bit that is still waiting and not being served: coalesce and flag it.
  always_comb begin
    pend_d = '0;
    drop_d = 1'b0;
    if (i_Enable) begin
      pend_d = (pend_q & ~grant) | evt;
      drop_d = |(evt & pend_q & ~grant);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      rr_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      prev_q <= i_Switches;
      pend_q <= pend_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
    end
  end

  move_fifo #(
    .WIDTH (2),
    .DEPTH (c_FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (i_Clk),
    .rst_ni      (i_Rst_n),
    .push_i      (|grant),
    .push_data_i (grant_idx),
    .pop_i       (fifo_pop),
    .flush_i     (~i_Enable),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (o_Fifo_Count),
    .head_o      (o_Move_Dir)
  );

  assign o_Move_Valid = ~fifo_empty;
  assign o_Drop       = drop_q;

endmodule
